// File: rtl/code_patch_si_writer.sv
// code_patch_si_writer
//   Serial-interface write engine for the code-patch table. Deserialises
//   framed writes (addr, patch word, even parity; MSB first) and issues one
//   handshaked write per good frame. Bad, aborted, disallowed or timed-out
//   frames are reported through wr_err_o / wr_err_code_o and never reach
//   the table.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   cfg_pat_gen_i         patch-generation enable, sampled in CHECK
//   si_write_i            frame envelope
//   si_bit_valid_i        qualifies si_data_i
//   si_data_i             serial bit, MSB first
//   patch_we_o            table write request (high for the whole of WRITE)
//   patch_addr_o          table write address, holds last written value
//   patch_data_o          table write data, holds last written value
//   patch_ack_i           table accepts write in the same cycle
//   wr_busy_o             any state other than IDLE
//   wr_done_o             one-cycle pulse after an accepted write
//   wr_err_o              one-cycle pulse on a rejected frame
//   wr_err_code_o         1 parity, 2 bad addr, 3 abort, 4 bit timeout,
//                         5 ack timeout, 6 disabled; held until next error
//
// State  | meaning
// IDLE   | waiting for si_write_i
// SHIFT  | collecting frame bits
// CHECK  | one cycle of enable/parity/address checks
// WRITE  | patch_we_o high, waiting for patch_ack_i
// DRAIN  | frame finished or rejected, waiting for si_write_i low

module code_patch_si_writer #(
  parameter int NUM_ENTRIES = 3,
  parameter int ADDR_W      = 2,
  parameter int DATA_W      = 22,
  parameter int TIMEOUT     = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_pat_gen_i,
  input  logic              si_write_i,
  input  logic              si_bit_valid_i,
  input  logic              si_data_i,
  output logic              patch_we_o,
  output logic [ADDR_W-1:0] patch_addr_o,
  output logic [DATA_W-1:0] patch_data_o,
  input  logic              patch_ack_i,
  output logic              wr_busy_o,
  output logic              wr_done_o,
  output logic              wr_err_o,
  output logic [2:0]        wr_err_code_o
);

  localparam int FRAME_W = ADDR_W + DATA_W + 1;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int TMR_W   = $clog2(TIMEOUT + 1);
  localparam int ENT_W   = ADDR_W + 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);
  localparam logic [ENT_W-1:0] ENTRIES  = ENT_W'(NUM_ENTRIES);

  localparam logic [2:0] ERR_PARITY  = 3'd1;
  localparam logic [2:0] ERR_ADDR    = 3'd2;
  localparam logic [2:0] ERR_ABORT   = 3'd3;
  localparam logic [2:0] ERR_BIT_TO  = 3'd4;
  localparam logic [2:0] ERR_ACK_TO  = 3'd5;
  localparam logic [2:0] ERR_DISABLE = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK,
    S_WRITE,
    S_DRAIN
  } state_t;

  state_t             state, state_n;
  logic [FRAME_W-1:0] shreg, shreg_n;
  logic [CNT_W-1:0]   bcnt, bcnt_n;
  logic [TMR_W-1:0]   tcnt, tcnt_n, tcnt_inc;
  logic               err_set, done_set, load_out;
  logic [2:0]         err_code_n;

  logic [ADDR_W-1:0]  fr_addr;
  logic [DATA_W-1:0]  fr_data;
  logic               fr_par_ok;

  assign fr_addr   = shreg[FRAME_W-1 -: ADDR_W];
  assign fr_data   = shreg[DATA_W:1];
  assign fr_par_ok = ~(^shreg);

  // Saturating so a long stall can never wrap back into the legal range.
  assign tcnt_inc = (tcnt == TMR_MAX) ? tcnt : tcnt + TMR_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bcnt_n     = bcnt;
    tcnt_n     = tcnt;
    err_set    = 1'b0;
    err_code_n = 3'd0;
    done_set   = 1'b0;
    load_out   = 1'b0;
    case (state)
      S_IDLE: begin
        if (si_write_i) begin
          state_n = S_SHIFT;
          shreg_n = '0;
          bcnt_n  = '0;
          tcnt_n  = '0;
          // A bit qualified in the start cycle is already bit 0.
          if (si_bit_valid_i) begin
            shreg_n = FRAME_W'(si_data_i);
            bcnt_n  = CNT_W'(1);
          end
        end
      end
      S_SHIFT: begin
        // A final bit arriving with the envelope's falling edge still
        // completes the frame.
        if (si_bit_valid_i && bcnt == LAST_BIT) begin
          shreg_n = {shreg[FRAME_W-2:0], si_data_i};
          bcnt_n  = bcnt + CNT_W'(1);
          state_n = S_CHECK;
        end else if (!si_write_i) begin
          err_set    = 1'b1;
          err_code_n = ERR_ABORT;
          state_n    = S_DRAIN;
        end else if (si_bit_valid_i) begin
          shreg_n = {shreg[FRAME_W-2:0], si_data_i};
          bcnt_n  = bcnt + CNT_W'(1);
          tcnt_n  = '0;
        end else begin
          tcnt_n = tcnt_inc;
          if (tcnt >= TMR_LAST) begin
            err_set    = 1'b1;
            err_code_n = ERR_BIT_TO;
            state_n    = S_DRAIN;
          end
        end
      end
      S_CHECK: begin
        state_n = S_DRAIN;
        err_set = 1'b1;
        if (!cfg_pat_gen_i)                err_code_n = ERR_DISABLE;
        else if (!fr_par_ok)               err_code_n = ERR_PARITY;
        else if ({1'b0, fr_addr} >= ENTRIES) err_code_n = ERR_ADDR;
        else begin
          err_set  = 1'b0;
          load_out = 1'b1;
          tcnt_n   = '0;
          state_n  = S_WRITE;
        end
      end
      S_WRITE: begin
        if (patch_ack_i) begin
          done_set = 1'b1;
          state_n  = S_DRAIN;
        end else begin
          tcnt_n = tcnt_inc;
          if (tcnt >= TMR_LAST) begin
            err_set    = 1'b1;
            err_code_n = ERR_ACK_TO;
            state_n    = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!si_write_i) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg         <= '0;
      bcnt          <= '0;
      tcnt          <= '0;
      patch_addr_o  <= '0;
      patch_data_o  <= '0;
      wr_done_o     <= 1'b0;
      wr_err_o      <= 1'b0;
      wr_err_code_o <= 3'd0;
    end else begin
      shreg     <= shreg_n;
      bcnt      <= bcnt_n;
      tcnt      <= tcnt_n;
      wr_done_o <= done_set;
      wr_err_o  <= err_set;
      if (err_set) wr_err_code_o <= err_code_n;
      if (load_out) begin
        patch_addr_o <= fr_addr;
        patch_data_o <= fr_data;
      end
    end
  end

  assign patch_we_o = (state == S_WRITE);
  assign wr_busy_o  = (state != S_IDLE);

endmodule

// File: tb/tb_code_patch_si_writer.sv
module tb_code_patch_si_writer;

  localparam int NUM_ENTRIES = 3;
  localparam int ADDR_W      = 2;
  localparam int DATA_W      = 22;
  localparam int TIMEOUT     = 64;
  localparam int FW          = ADDR_W + DATA_W + 1;
  localparam int TAIL        = TIMEOUT + 12;
  localparam int LIMIT       = 600;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              cfg_pat_gen_i = 1'b0;
  logic              si_write_i = 1'b0;
  logic              si_bit_valid_i = 1'b0;
  logic              si_data_i = 1'b0;
  logic              patch_we_o;
  logic [ADDR_W-1:0] patch_addr_o;
  logic [DATA_W-1:0] patch_data_o;
  logic              patch_ack_i = 1'b0;
  logic              wr_busy_o;
  logic              wr_done_o;
  logic              wr_err_o;
  logic [2:0]        wr_err_code_o;

  code_patch_si_writer #(
    .NUM_ENTRIES(NUM_ENTRIES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_pat_gen_i(cfg_pat_gen_i),
    .si_write_i(si_write_i), .si_bit_valid_i(si_bit_valid_i), .si_data_i(si_data_i),
    .patch_we_o(patch_we_o), .patch_addr_o(patch_addr_o), .patch_data_o(patch_data_o),
    .patch_ack_i(patch_ack_i), .wr_busy_o(wr_busy_o), .wr_done_o(wr_done_o),
    .wr_err_o(wr_err_o), .wr_err_code_o(wr_err_code_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int gap_tbl[FW];

  // Observations of the last run_frame call.
  int                obs_we_first, obs_we_cnt, obs_done, obs_err, obs_done_k, obs_err_k;
  int                obs_last_k, obs_idle_lat, obs_code;
  logic [ADDR_W-1:0] obs_addr;
  logic [DATA_W-1:0] obs_data;
  bit                obs_stable, obs_both, obs_rst_ok, obs_busy_held;

  function automatic logic [FW-1:0] mk_frame(input logic [ADDR_W-1:0] a,
                                             input logic [DATA_W-1:0] d, input bit bad_par);
    logic p;
    p = (^{a, d}) ^ bad_par;
    return {a, d, p};
  endfunction

  function automatic int max_gap(input int nsend);
    int m;
    m = 0;
    for (int i = 1; i < nsend; i++) if (gap_tbl[i] > m) m = gap_tbl[i];
    return m;
  endfunction

  // Reference outcome of a frame: 0 = written, otherwise the error code.
  function automatic int model_code(input logic [FW-1:0] f, input int nsend, input int mgap,
                                    input bit cfg, input int ack_delay);
    logic [ADDR_W-1:0] a;
    a = f[FW-1 -: ADDR_W];
    if (nsend < FW) return 3;
    if (mgap >= TIMEOUT) return 4;
    if (!cfg) return 6;
    if (^f) return 1;
    if (int'(a) >= NUM_ENTRIES) return 2;
    if (ack_delay < 0 || ack_delay >= TIMEOUT) return 5;
    return 0;
  endfunction

  task automatic clear_gaps();
    for (int i = 0; i < FW; i++) gap_tbl[i] = 0;
  endtask

  // Sends nsend bits of frame (gaps from gap_tbl), holds the envelope for a
  // tail while answering the table handshake, then drops it and waits for IDLE.
  task automatic run_frame(input logic [FW-1:0] frame, input int nsend, input bit cfg,
                           input int ack_delay, input int rst_k, input int rst_we);
    int  bi, gcnt, tail, phase, we_seen, drop_k;
    bit  hold, killed, rst_pending;
    obs_we_first = -1; obs_we_cnt = 0; obs_done = 0; obs_err = 0; obs_done_k = -1;
    obs_err_k = -1; obs_last_k = -1; obs_idle_lat = -1; obs_code = 0;
    obs_addr = '0; obs_data = '0;
    obs_stable = 1; obs_both = 0; obs_rst_ok = 1; obs_busy_held = 0;
    bi = 0; gcnt = 0; tail = 0; phase = 0; we_seen = 0; drop_k = 0;
    hold = (nsend == FW); killed = 0; rst_pending = 0;
    cfg_pat_gen_i = cfg;
    for (int k = 0; k < LIMIT; k++) begin
      @(negedge clk_i);
      if (rst_pending) begin
        rst_pending = 0;
        rst_i = 1'b0;
        if (patch_we_o || wr_busy_o || wr_done_o || wr_err_o || wr_err_code_o != 3'd0 ||
            patch_addr_o != '0 || patch_data_o != '0) obs_rst_ok = 0;
      end
      if (patch_we_o) begin
        if (obs_we_first < 0) begin
          obs_we_first = k; obs_addr = patch_addr_o; obs_data = patch_data_o;
        end else if (patch_addr_o !== obs_addr || patch_data_o !== obs_data) obs_stable = 0;
        obs_we_cnt++;
      end
      if (wr_done_o) begin obs_done++; obs_done_k = k; end
      if (wr_err_o) begin obs_err++; obs_err_k = k; obs_code = int'(wr_err_code_o); end
      if (wr_done_o && wr_err_o) obs_both = 1;
      if (phase == 2 && !wr_busy_o) begin
        obs_idle_lat = k - drop_k;
        break;
      end
      if (patch_we_o) begin
        we_seen++;
        patch_ack_i = (ack_delay >= 0) && (we_seen - 1 >= ack_delay);
      end else begin
        patch_ack_i = 1'($urandom_range(0, 1));
      end
      if (!killed && ((rst_k >= 0 && k == rst_k) ||
                      (rst_we > 0 && patch_we_o && we_seen == rst_we))) begin
        rst_i = 1'b1; rst_pending = 1; killed = 1;
        phase = 2; drop_k = k;
        si_write_i = 1'b0; si_bit_valid_i = 1'b0;
      end else if (phase == 0) begin
        si_write_i = 1'b1;
        if (gcnt < gap_tbl[bi]) begin
          si_bit_valid_i = 1'b0; gcnt++;
        end else begin
          si_bit_valid_i = 1'b1; si_data_i = frame[FW-1-bi];
          bi++; gcnt = 0;
          if (bi == nsend) begin obs_last_k = k; phase = 1; end
        end
      end else if (phase == 1) begin
        si_write_i = hold; si_bit_valid_i = 1'b0; tail++;
        if (tail == TAIL) begin
          obs_busy_held = wr_busy_o;
          phase = 2; drop_k = k; si_write_i = 1'b0;
        end
      end else begin
        si_write_i = 1'b0; si_bit_valid_i = 1'b0;
      end
    end
    si_write_i = 1'b0; si_bit_valid_i = 1'b0; patch_ack_i = 1'b0; rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    total++; if (patch_we_o !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", patch_we_o); end
    total++; if (wr_busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", wr_busy_o); end
    total++; if (wr_done_o !== 1'b0 || wr_err_o !== 1'b0) begin bad++; $display("FAIL reset_pulses done=%b err=%b want=0", wr_done_o, wr_err_o); end
    total++; if (wr_err_code_o !== 3'd0) begin bad++; $display("FAIL reset_code got=%0d want=0", wr_err_code_o); end
    total++; if (patch_addr_o !== '0 || patch_data_o !== '0) begin bad++; $display("FAIL reset_addr_data got=%0h/%0h want=0", patch_addr_o, patch_data_o); end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_good_write();
    clear_gaps();
    run_frame(mk_frame(2'b01, 22'h2AAAAA, 0), FW, 1, 0, -1, 0);
    total++; if (obs_we_first !== obs_last_k + 2) begin bad++; $display("FAIL good_we_latency got=%0d want=%0d", obs_we_first, obs_last_k + 2); end
    total++; if (obs_addr !== 2'd1 || obs_data !== 22'h2AAAAA) begin bad++; $display("FAIL good_addr_data got=%0h/%0h want=1/2aaaaa", obs_addr, obs_data); end
    total++; if (obs_we_cnt !== 1) begin bad++; $display("FAIL good_we_cycles got=%0d want=1", obs_we_cnt); end
    total++; if (obs_done !== 1 || obs_done_k !== obs_we_first + 1) begin bad++; $display("FAIL good_done got=%0d@%0d want=1@%0d", obs_done, obs_done_k, obs_we_first + 1); end
    total++; if (obs_err !== 0) begin bad++; $display("FAIL good_no_err got=%0d want=0", obs_err); end
    total++; if (obs_idle_lat !== 1) begin bad++; $display("FAIL good_idle got=%0d want=1", obs_idle_lat); end
  endtask

  task automatic test_parity();
    clear_gaps();
    run_frame(mk_frame(2'b01, 22'h2AAAAA, 1), FW, 1, 0, -1, 0);
    total++; if (obs_err !== 1 || obs_code !== 1) begin bad++; $display("FAIL parity_code got=%0d x%0d want=1 x1", obs_code, obs_err); end
    total++; if (obs_err_k !== obs_last_k + 2) begin bad++; $display("FAIL parity_err_time got=%0d want=%0d", obs_err_k, obs_last_k + 2); end
    total++; if (obs_we_cnt !== 0 || obs_done !== 0) begin bad++; $display("FAIL parity_no_write we=%0d done=%0d want=0", obs_we_cnt, obs_done); end
    total++; if (obs_busy_held !== 1'b1) begin bad++; $display("FAIL parity_drain_hold got=%b want=1", obs_busy_held); end
    total++; if (obs_idle_lat !== 1) begin bad++; $display("FAIL parity_idle got=%0d want=1", obs_idle_lat); end
  endtask

  task automatic test_addr_disabled();
    clear_gaps();
    run_frame(mk_frame(2'b11, 22'h0F0F0F, 0), FW, 1, 0, -1, 0);
    total++; if (obs_code !== 2 || obs_we_cnt !== 0) begin bad++; $display("FAIL bad_addr got=%0d we=%0d want=2 we=0", obs_code, obs_we_cnt); end
    run_frame(mk_frame(2'b10, 22'h123456, 0), FW, 0, 0, -1, 0);
    total++; if (obs_code !== 6 || obs_we_cnt !== 0) begin bad++; $display("FAIL disabled got=%0d we=%0d want=6 we=0", obs_code, obs_we_cnt); end
    // disable outranks parity
    run_frame(mk_frame(2'b10, 22'h123456, 1), FW, 0, 0, -1, 0);
    total++; if (obs_code !== 6) begin bad++; $display("FAIL disabled_prio got=%0d want=6", obs_code); end
  endtask

  task automatic test_abort_timeout();
    clear_gaps();
    run_frame(mk_frame(2'b00, 22'h3FFFFF, 0), 10, 1, 0, -1, 0);
    total++; if (obs_code !== 3 || obs_err_k !== obs_last_k + 2) begin bad++; $display("FAIL abort got=%0d@%0d want=3@%0d", obs_code, obs_err_k, obs_last_k + 2); end
    gap_tbl[12] = TIMEOUT + 6;
    run_frame(mk_frame(2'b00, 22'h3FFFFF, 0), FW, 1, 0, -1, 0);
    total++; if (obs_code !== 4 || obs_we_cnt !== 0 || obs_done !== 0) begin bad++; $display("FAIL bit_timeout got=%0d we=%0d want=4 we=0", obs_code, obs_we_cnt); end
    gap_tbl[12] = TIMEOUT - 4;
    run_frame(mk_frame(2'b10, 22'h155555, 0), FW, 1, 0, -1, 0);
    total++; if (obs_done !== 1 || obs_err !== 0 || obs_addr !== 2'd2 || obs_data !== 22'h155555) begin bad++; $display("FAIL long_gap_ok done=%0d err=%0d addr=%0h data=%0h want 1 0 2 155555", obs_done, obs_err, obs_addr, obs_data); end
    clear_gaps();
    run_frame(mk_frame(2'b00, 22'h000001, 0), FW, 1, 0, -1, 0);
    total++; if (obs_done !== 1 || obs_data !== 22'h000001) begin bad++; $display("FAIL after_err_write done=%0d data=%0h want=1/1", obs_done, obs_data); end
  endtask

  task automatic test_ack();
    clear_gaps();
    run_frame(mk_frame(2'b01, 22'h0ABCDE, 0), FW, 1, 5, -1, 0);
    total++; if (obs_we_cnt !== 6 || !obs_stable) begin bad++; $display("FAIL ack5_we got=%0d stable=%b want=6 stable=1", obs_we_cnt, obs_stable); end
    total++; if (obs_done !== 1 || obs_done_k !== obs_we_first + 6) begin bad++; $display("FAIL ack5_done got=%0d@%0d want=1@%0d", obs_done, obs_done_k, obs_we_first + 6); end
    run_frame(mk_frame(2'b01, 22'h0ABCDE, 0), FW, 1, -1, -1, 0);
    total++; if (obs_code !== 5 || obs_done !== 0) begin bad++; $display("FAIL ack_to_code got=%0d done=%0d want=5 done=0", obs_code, obs_done); end
    total++; if (obs_we_cnt !== TIMEOUT || obs_err_k !== obs_we_first + TIMEOUT) begin bad++; $display("FAIL ack_to_time we=%0d err@%0d want we=%0d err@%0d", obs_we_cnt, obs_err_k, TIMEOUT, obs_we_first + TIMEOUT); end
  endtask

  task automatic test_reset_mid();
    clear_gaps();
    run_frame(mk_frame(2'b01, 22'h33CC33, 0), FW, 1, 0, 12, 0);
    total++; if (!obs_rst_ok) begin bad++; $display("FAIL rst_shift_outputs got=nonzero want=0"); end
    total++; if (obs_done !== 0 || obs_err !== 0 || obs_we_cnt !== 0) begin bad++; $display("FAIL rst_shift_pulses done=%0d err=%0d we=%0d want=0", obs_done, obs_err, obs_we_cnt); end
    run_frame(mk_frame(2'b10, 22'h1E1E1E, 0), FW, 1, -1, -1, 3);
    total++; if (!obs_rst_ok || obs_we_cnt !== 3) begin bad++; $display("FAIL rst_write_outputs ok=%b we=%0d want ok=1 we=3", obs_rst_ok, obs_we_cnt); end
    total++; if (obs_done !== 0 || obs_err !== 0) begin bad++; $display("FAIL rst_write_pulses done=%0d err=%0d want=0", obs_done, obs_err); end
    run_frame(mk_frame(2'b10, 22'h1E1E1E, 0), FW, 1, 2, -1, 0);
    total++; if (obs_done !== 1 || obs_addr !== 2'd2 || obs_data !== 22'h1E1E1E) begin bad++; $display("FAIL rst_recover done=%0d addr=%0h data=%0h want 1 2 1e1e1e", obs_done, obs_addr, obs_data); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic [FW-1:0]     f;
      bit                cfg;
      int                nsend, ackd, exp_code, exp_we, got_code;
      a = ADDR_W'($urandom_range(0, 3));
      d = DATA_W'($urandom);
      f = mk_frame(a, d, $urandom_range(0, 7) == 0);
      cfg = ($urandom_range(0, 7) != 0);
      ackd = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
      nsend = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, FW - 1)) : FW;
      clear_gaps();
      for (int i = 1; i < FW; i++) if ($urandom_range(0, 3) == 0) gap_tbl[i] = int'($urandom_range(1, 4));
      exp_code = model_code(f, nsend, max_gap(nsend), cfg, ackd);
      exp_we = (exp_code == 0) ? ackd + 1 : (exp_code == 5) ? TIMEOUT : 0;
      run_frame(f, nsend, cfg, ackd, -1, 0);
      got_code = (obs_err > 0) ? obs_code : 0;
      total++; if (got_code !== exp_code || obs_done + obs_err !== 1 || obs_both) begin bad++; $display("FAIL rand%0d_outcome code=%0d done=%0d err=%0d want code=%0d", it, got_code, obs_done, obs_err, exp_code); end
      total++; if (obs_we_cnt !== exp_we || !obs_stable) begin bad++; $display("FAIL rand%0d_we cycles=%0d stable=%b want=%0d", it, obs_we_cnt, obs_stable, exp_we); end
      if (exp_code == 0) begin
        total++; if (obs_addr !== a || obs_data !== d) begin bad++; $display("FAIL rand%0d_addr_data got=%0h/%0h want=%0h/%0h", it, obs_addr, obs_data, a, d); end
      end
      total++; if (obs_idle_lat !== 1) begin bad++; $display("FAIL rand%0d_idle got=%0d want=1", it, obs_idle_lat); end
    end
  endtask

  initial begin
    clear_gaps();
    test_reset();
    test_good_write();
    test_parity();
    test_addr_disabled();
    test_abort_timeout();
    test_ack();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
